mem_lsu: RTL and testbench

Parametrised load/store unit between the backend execute stage and the data-memory port. Accepts one load or store per valid/ready request and issues word-aligned read/write transactions on the memory channels. Generates byte-accurate store masks and returns aligned, sign- or zero-extended load data on a response handshake. Adds misalignment detection and pipeline flush, with at most one access in flight.

---
 rtl/mem_lsu_pkg.sv | 24 ++
 rtl/mem_lsu_if.sv | 46 ++++
 rtl/mem_lsu_align.sv | 48 ++++
 rtl/mem_lsu.sv | 112 +++++++++++
 tb/tb_mem_lsu.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types and helpers for the load/store unit
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    function automatic int size_bytes(input size_e size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - request, response and memory channel bundle of the load/store unit
interface mem_lsu_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  flush;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_load;
    logic                  req_is_store;
    logic                  req_unsigned;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_misaligned;
    logic                  read_valid;
    logic                  read_ready;
    logic [ADDR_WIDTH-1:0] read_address;
    logic                  read_done;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  write_valid;
    logic                  write_ready;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] write_mask;
    logic                  write_done;

    modport master (
        output flush, req_valid, req_is_load, req_is_store, req_unsigned, req_size,
               req_addr, req_wdata, resp_ready, read_ready, read_done, read_data,
               write_ready, write_done,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, read_valid,
               read_address, write_valid, write_address, write_data, write_mask
    );

    modport slave (
        input  flush, req_valid, req_is_load, req_is_store, req_unsigned, req_size,
               req_addr, req_wdata, resp_ready, read_ready, read_done, read_data,
               write_ready, write_done,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, read_valid,
               read_address, write_valid, write_address, write_data, write_mask
    );
endinterface

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - store data/mask placement and load data extraction/extension
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
    input  size_e                           size,
    input  logic                            is_unsigned,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [DATA_WIDTH-1:0]           rdata,
    output logic [DATA_WIDTH-1:0]           st_data,
    output logic [DATA_WIDTH-1:0]           st_mask,
    output logic [DATA_WIDTH-1:0]           ld_data
);
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic                  sign;
    int                    nbits;
    int                    first;

    always_comb begin
        st_mask = '0;
        keep    = '0;
        sign    = 1'b0;
        nbits   = 8 * size_bytes(size);
        first   = int'(offset);
        st_data = wdata << {offset, 3'b000};
        shifted = rdata >> {offset, 3'b000};
        for (int b = 0; b < NBYTES; b++) begin
            if (b >= first && b < first + size_bytes(size)) begin
                st_mask[b*8 +: 8] = 8'hFF;
            end
        end
        // A size wider than the bus keeps every bit and never sign-extends.
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < nbits) begin
                keep[i] = 1'b1;
            end
            if (i == nbits - 1) begin
                sign = shifted[i];
            end
        end
        ld_data = (shifted & keep) | (~keep & {DATA_WIDTH{sign & ~is_unsigned}});
    end
endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - single-outstanding load/store unit: FSM and captured request fields
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input logic     clock,
    input logic     reset,
    mem_lsu_if.slave bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NBYTES);

    state_e                state, state_nx;
    logic                  uns_q;
    size_e                 size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mis_q;
    logic                  killed_q;

    size_e                 size_in;
    logic [2:0]            amask_in;
    logic                  fault_in;
    logic [DATA_WIDTH-1:0] st_data, st_mask, ld_data;

    assign size_in  = size_e'(bus.req_size);
    assign amask_in = 3'(size_bytes(size_in) - 1);
    assign fault_in = (|(bus.req_addr[2:0] & amask_in)) || (size_in == SZ_D && DATA_WIDTH == 32);

    mem_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .offset      (addr_q[OFF_W-1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (bus.read_data),
        .st_data     (st_data),
        .st_mask     (st_mask),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.req_valid && !bus.flush) begin
                if (fault_in || !(bus.req_is_load || bus.req_is_store)) state_nx = ST_RESP;
                else if (bus.req_is_load)                               state_nx = ST_RD_REQ;
                else                                                    state_nx = ST_WR_REQ;
            end
            ST_RD_REQ: begin
                if (bus.flush)           state_nx = ST_IDLE;
                else if (bus.read_ready) state_nx = ST_RD_WAIT;
            end
            // A flush while waiting cannot cancel the memory access; it only suppresses the response.
            ST_RD_WAIT: if (bus.read_done) state_nx = (killed_q || bus.flush) ? ST_IDLE : ST_RESP;
            ST_WR_REQ: begin
                if (bus.flush)            state_nx = ST_IDLE;
                else if (bus.write_ready) state_nx = ST_WR_WAIT;
            end
            ST_WR_WAIT: if (bus.write_done) state_nx = (killed_q || bus.flush) ? ST_IDLE : ST_RESP;
            ST_RESP: if (bus.flush || bus.resp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            uns_q    <= 1'b0;
            size_q   <= SZ_B;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                uns_q   <= bus.req_unsigned;
                size_q  <= size_in;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
                mis_q   <= fault_in;
            end
            if (state == ST_RD_WAIT && bus.read_done) begin
                rdata_q <= ld_data;
            end
            if (state == ST_IDLE) begin
                killed_q <= 1'b0;
            end else if ((state == ST_RD_WAIT || state == ST_WR_WAIT) && bus.flush) begin
                killed_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready       = (state == ST_IDLE);
    assign bus.read_valid      = (state == ST_RD_REQ);
    assign bus.read_address    = bus.read_valid ? (addr_q >> OFF_W) : '0;
    assign bus.write_valid     = (state == ST_WR_REQ);
    assign bus.write_address   = bus.write_valid ? (addr_q >> OFF_W) : '0;
    assign bus.write_data      = bus.write_valid ? st_data : '0;
    assign bus.write_mask      = bus.write_valid ? st_mask : '0;
    assign bus.resp_valid      = (state == ST_RESP);
    assign bus.resp_rdata      = bus.resp_valid ? rdata_q : '0;
    assign bus.resp_misaligned = bus.resp_valid & mis_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed scoreboard bench for mem_lsu at 64- and 32-bit data widths
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    typedef struct packed {
        logic [63:0] rdata;
        logic        mis;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t sb32[$];

    mem_lsu_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) b64 ();
    mem_lsu_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) b32 ();

    mem_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) u64 (.clock(clock), .reset(reset), .bus(b64));
    mem_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) u32 (.clock(clock), .reset(reset), .bus(b32));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic ld, input logic st, input logic uns, input logic [1:0] sz,
                            input logic [63:0] addr, input logic [63:0] wdata);
        b64.req_is_load  = ld;
        b64.req_is_store = st;
        b64.req_unsigned = uns;
        b64.req_size     = sz;
        b64.req_addr     = addr;
        b64.req_wdata    = wdata;
        b64.req_valid    = 1'b1;
        tick();
        b64.req_valid    = 1'b0;
        b64.req_is_load  = 1'b0;
        b64.req_is_store = 1'b0;
        b64.req_wdata    = '0;
    endtask

    task automatic wait_resp(input string tag, input int budget);
        exp_t e;
        int   n = 0;
        while (!b64.resp_valid && n < budget) begin
            tick();
            n++;
        end
        if (!b64.resp_valid || sb.size() == 0) begin
            check({tag, "_resp_timeout"}, {63'd0, b64.resp_valid}, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, b64.resp_rdata, e.rdata);
            check({tag, "_mis"}, {63'd0, b64.resp_misaligned}, {63'd0, e.mis});
            b64.resp_ready = 1'b1;
            tick();
            b64.resp_ready = 1'b0;
        end
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] word, input logic [63:0] exp);
        sb.push_back('{rdata: exp, mis: 1'b0});
        send_req(1'b1, 1'b0, uns, sz, addr, 64'd0);
        check({tag, "_rv"}, {63'd0, b64.read_valid}, 64'd1);
        check({tag, "_raddr"}, b64.read_address, addr >> 3);
        tick();
        b64.read_data = word;
        b64.read_done = 1'b1;
        tick();
        b64.read_done = 1'b0;
        b64.read_data = '0;
        check({tag, "_t3"}, {63'd0, b64.resp_valid}, 64'd1);
        wait_resp(tag, 4);
    endtask

    task automatic do_store(input string tag, input logic [1:0] sz, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] exp_data, input logic [63:0] exp_mask);
        sb.push_back('{rdata: 64'd0, mis: 1'b0});
        send_req(1'b0, 1'b1, 1'b0, sz, addr, wdata);
        check({tag, "_wv"}, {63'd0, b64.write_valid}, 64'd1);
        check({tag, "_waddr"}, b64.write_address, addr >> 3);
        check({tag, "_wdata"}, b64.write_data, exp_data);
        check({tag, "_wmask"}, b64.write_mask, exp_mask);
        check({tag, "_rdy"}, {63'd0, b64.req_ready}, 64'd0);
        tick();
        check({tag, "_wv_off"}, {63'd0, b64.write_valid}, 64'd0);
        check({tag, "_wdata_off"}, b64.write_data, 64'd0);
        b64.write_done = 1'b1;
        tick();
        b64.write_done = 1'b0;
        check({tag, "_t3"}, {63'd0, b64.resp_valid}, 64'd1);
        wait_resp(tag, 4);
        check({tag, "_idle"}, {63'd0, b64.req_ready}, 64'd1);
    endtask

    initial begin
        exp_t e;
        b64.flush = 0; b64.req_valid = 0; b64.req_is_load = 0; b64.req_is_store = 0;
        b64.req_unsigned = 0; b64.req_size = 0; b64.req_addr = '0; b64.req_wdata = '0;
        b64.resp_ready = 0; b64.read_ready = 1; b64.read_done = 0; b64.read_data = '0;
        b64.write_ready = 1; b64.write_done = 0;
        b32.flush = 0; b32.req_valid = 0; b32.req_is_load = 0; b32.req_is_store = 0;
        b32.req_unsigned = 0; b32.req_size = 0; b32.req_addr = '0; b32.req_wdata = '0;
        b32.resp_ready = 0; b32.read_ready = 1; b32.read_done = 0; b32.read_data = '0;
        b32.write_ready = 1; b32.write_done = 0;

        tick();
        tick();
        reset = 1'b0;
        check("rst_req_ready", {63'd0, b64.req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, b64.resp_valid}, 64'd0);
        check("rst_read_valid", {63'd0, b64.read_valid}, 64'd0);
        check("rst_write_valid", {63'd0, b64.write_valid}, 64'd0);
        check("rst_write_mask", b64.write_mask, 64'd0);
        check("rst_resp_rdata", b64.resp_rdata, 64'd0);

        do_store("st_h", 2'd1, 64'h1006, 64'hABCD, 64'hABCD_0000_0000_0000, 64'hFFFF_0000_0000_0000);
        do_store("st_b", 2'd0, 64'h1001, 64'h5A, 64'h5A00, 64'hFF00);
        do_store("st_w", 2'd2, 64'h1004, 64'h1122_3344, 64'h1122_3344_0000_0000, 64'hFFFF_FFFF_0000_0000);
        do_store("st_d", 2'd3, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);

        do_load("ld_b_s", 2'd0, 1'b0, 64'h1003, 64'h0706_0504_8002_0100, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("ld_b_u", 2'd0, 1'b1, 64'h1003, 64'h0706_0504_8002_0100, 64'h0000_0000_0000_0080);
        do_load("ld_h_s", 2'd1, 1'b0, 64'h1006, 64'h8123_0504_0302_0100, 64'hFFFF_FFFF_FFFF_8123);
        do_load("ld_w_u", 2'd2, 1'b1, 64'h1004, 64'hDEAD_BEEF_0302_0100, 64'h0000_0000_DEAD_BEEF);
        do_load("ld_w_s", 2'd2, 1'b0, 64'h1004, 64'hDEAD_BEEF_0302_0100, 64'hFFFF_FFFF_DEAD_BEEF);
        do_load("ld_d", 2'd3, 1'b0, 64'h1000, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211);

        sb.push_back('{rdata: 64'd0, mis: 1'b1});
        send_req(1'b1, 1'b0, 1'b0, 2'd2, 64'h1002, 64'd0);
        check("mis_t1", {63'd0, b64.resp_valid}, 64'd1);
        check("mis_no_read", {63'd0, b64.read_valid}, 64'd0);
        wait_resp("mis_w", 2);

        sb.push_back('{rdata: 64'd0, mis: 1'b0});
        send_req(1'b0, 1'b0, 1'b0, 2'd3, 64'h1000, 64'hFFFF);
        check("nop_t1", {63'd0, b64.resp_valid}, 64'd1);
        wait_resp("nop", 2);

        b64.read_ready = 1'b0;
        sb.push_back('{rdata: 64'h7654, mis: 1'b0});
        send_req(1'b1, 1'b0, 1'b0, 2'd1, 64'h2002, 64'd0);
        for (int c = 0; c < 3; c++) begin
            check("stall_rv", {63'd0, b64.read_valid}, 64'd1);
            check("stall_raddr", b64.read_address, 64'h400);
            tick();
        end
        b64.read_ready = 1'b1;
        tick();
        b64.read_data = 64'h0000_0000_7654_0000;
        b64.read_done = 1'b1;
        tick();
        b64.read_done = 1'b0;
        b64.read_data = '0;
        for (int c = 0; c < 2; c++) begin
            check("hold_resp_valid", {63'd0, b64.resp_valid}, 64'd1);
            check("hold_rdata", b64.resp_rdata, 64'h7654);
            check("hold_req_ready", {63'd0, b64.req_ready}, 64'd0);
            tick();
        end
        wait_resp("stall", 2);
        check("stall_idle", {63'd0, b64.req_ready}, 64'd1);

        send_req(1'b1, 1'b0, 1'b0, 2'd3, 64'h3000, 64'd0);
        tick();
        b64.flush = 1'b1;
        tick();
        b64.flush = 1'b0;
        check("flush_wait_rdy", {63'd0, b64.req_ready}, 64'd0);
        tick();
        b64.read_data = 64'hFFFF_FFFF_FFFF_FFFF;
        b64.read_done = 1'b1;
        tick();
        b64.read_done = 1'b0;
        b64.read_data = '0;
        check("flush_no_resp", {63'd0, b64.resp_valid}, 64'd0);
        check("flush_idle", {63'd0, b64.req_ready}, 64'd1);
        tick();
        check("flush_no_resp2", {63'd0, b64.resp_valid}, 64'd0);
        do_load("after_flush", 2'd2, 1'b1, 64'h3004, 64'h1234_5678_0000_0000, 64'h1234_5678);

        b64.read_ready = 1'b0;
        send_req(1'b1, 1'b0, 1'b0, 2'd0, 64'h3001, 64'd0);
        b64.flush = 1'b1;
        tick();
        b64.flush = 1'b0;
        b64.read_ready = 1'b1;
        check("flush_rdreq_rv", {63'd0, b64.read_valid}, 64'd0);
        check("flush_rdreq_idle", {63'd0, b64.req_ready}, 64'd1);

        sb32.push_back('{rdata: 64'd0, mis: 1'b1});
        b32.req_is_load = 1'b1;
        b32.req_size    = 2'd3;
        b32.req_addr    = 64'h10;
        b32.req_valid   = 1'b1;
        tick();
        b32.req_valid   = 1'b0;
        b32.req_is_load = 1'b0;
        e = sb32.pop_front();
        check("dw32_d_valid", {63'd0, b32.resp_valid}, 64'd1);
        check("dw32_d_mis", {63'd0, b32.resp_misaligned}, {63'd0, e.mis});
        check("dw32_d_rdata", {32'd0, b32.resp_rdata}, e.rdata);
        check("dw32_d_no_read", {63'd0, b32.read_valid}, 64'd0);
        b32.resp_ready = 1'b1;
        tick();
        b32.resp_ready = 1'b0;

        b32.req_is_store = 1'b1;
        b32.req_size     = 2'd2;
        b32.req_addr     = 64'h8;
        b32.req_wdata    = 32'h1234_5678;
        b32.req_valid    = 1'b1;
        tick();
        b32.req_valid    = 1'b0;
        b32.req_is_store = 1'b0;
        check("dw32_st_waddr", b32.write_address, 64'h2);
        check("dw32_st_wmask", {32'd0, b32.write_mask}, 64'hFFFF_FFFF);
        check("dw32_st_wdata", {32'd0, b32.write_data}, 64'h1234_5678);
        tick();
        b32.write_done = 1'b1;
        tick();
        b32.write_done = 1'b0;
        check("dw32_st_resp", {63'd0, b32.resp_valid}, 64'd1);
        check("dw32_st_mis", {63'd0, b32.resp_misaligned}, 64'd0);
        b32.resp_ready = 1'b1;
        tick();
        b32.resp_ready = 1'b0;
        check("dw32_idle", {63'd0, b32.req_ready}, 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
